truth_table_checker: RTL

//  Self-checking stimulus/response engine for small combinational DUTs (3-input AND by default).

---
 rtl/tt_pkg.sv | 16 +
 rtl/settle_timer.sv | 28 ++
 rtl/truth_table_checker.sv | 75 +++++++
 3 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: FSM state encodings and width helper shared by the truth-table checker
package tt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Smallest r with 2**r >= v; evaluated at elaboration for counter widths.
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts 0..SETTLE-1 while enabled and flags the final count
module settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = SETTLE > 1 ? clog2(SETTLE) : 1;
    localparam logic [W-1:0] LAST = W'(SETTLE - 1);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;

    // Count up while enabled, parking at the last count until cleared.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + ONE;
    end

    assign expired = cnt == LAST;

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every DUT input vector and scores dutOut against TRUTH; define CHECKER_STOP_ON_ERR_EN to stop at the first mismatch
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int N_IN = 3,
    parameter logic [(1<<N_IN)-1:0] TRUTH = 8'b1000_0000,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dutOut,
    output logic [N_IN-1:0] vecOut,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   errCount,
    output logic [N_IN-1:0] firstErr
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [N_IN-1:0] VEC_ONE = 1;
    localparam logic [N_IN:0] ERR_ONE = 1;

    logic [1:0] state;
    logic       expired;
    logic       mismatch;
    logic       finish;

    settle_timer #(.SETTLE(SETTLE)) timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_APPLY),
        .en     (state == ST_APPLY),
        .expired(expired)
    );

    assign mismatch = dutOut != TRUTH[vecOut];
`ifdef CHECKER_STOP_ON_ERR_EN
    assign finish = mismatch || vecOut == LAST_VEC;
`else
    assign finish = vecOut == LAST_VEC;
`endif

    // Sweep FSM: vector counter and mismatch scoreboard advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vecOut   <= '0;
            errCount <= '0;
            firstErr <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) begin
                    state    <= ST_APPLY;
                    vecOut   <= '0;
                    errCount <= '0;
                    firstErr <= '0;
                end
                ST_APPLY: if (expired) state <= ST_CHECK;
                default: begin
                    if (mismatch) errCount <= errCount + ERR_ONE;
                    if (mismatch && errCount == '0) firstErr <= vecOut;
                    state <= finish ? ST_DONE : ST_APPLY;
                    if (!finish) vecOut <= vecOut + VEC_ONE;
                end
            endcase
        end
    end

    assign busy = state == ST_APPLY || state == ST_CHECK;
    assign done = state == ST_DONE;
    assign pass = done && errCount == '0;

endmodule
